// File: rtl/mips_exec_controller_if.sv
// Command, status and pipeline-control signals between the host/debug side,
// the MIPS datapath and the execution controller.
interface mips_exec_controller_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              cmd_valid;
  logic [1:0]        cmd;
  logic              cmd_ready;
  logic              halt_fetched;
  logic [ADDR_W-1:0] pc;
  logic              break_en;
  logic [ADDR_W-1:0] break_addr;
  logic              pipe_enable;
  logic              fetch_enable;
  logic              pipe_flush;
  logic              halted;
  logic              done;
  logic [CNT_W-1:0]  cycle_count;

  // Host/datapath side: issues commands and reports PC/halt status.
  modport master (
    output cmd_valid, cmd, halt_fetched, pc, break_en, break_addr,
    input  cmd_ready, pipe_enable, fetch_enable, pipe_flush, halted, done,
           cycle_count
  );

  // Controller side.
  modport slave (
    input  cmd_valid, cmd, halt_fetched, pc, break_en, break_addr,
    output cmd_ready, pipe_enable, fetch_enable, pipe_flush, halted, done,
           cycle_count
  );
endinterface

// File: rtl/mips_exec_controller.sv
// Execution sequencer for the 5-stage MIPS pipeline: RUN / STEP / breakpoint,
// HALT detection with a fixed-length drain, and CLEAR flush.
module mips_exec_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int ADDR_W       = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips_exec_controller_if.slave   ctrl
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP,
    S_DRAIN,
    S_HALTED,
    S_FLUSH
  } state_e;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_RUN   = 2'b01,
    CMD_STEP  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  state_e             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   count_q, count_d;

  cmd_e cmd;
  logic cmd_ready;
  logic cmd_accept;
  logic break_hit;
  logic pipe_enable;

  assign cmd         = cmd_e'(ctrl.cmd);
  assign cmd_ready   = (state_q == S_IDLE) || (state_q == S_HALTED);
  assign cmd_accept  = ctrl.cmd_valid && cmd_ready;
  assign break_hit   = ctrl.break_en && (ctrl.pc == ctrl.break_addr);
  assign pipe_enable = (state_q == S_RUN) || (state_q == S_STEP) ||
                       (state_q == S_DRAIN);

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          unique case (cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: state_d = S_FLUSH;
            default:   state_d = S_IDLE;
          endcase
        end
      end

      // Halt outranks the breakpoint when both occur in the same cycle.
      S_RUN: begin
        if (ctrl.halt_fetched) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (break_hit) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_STEP: begin
        if (ctrl.halt_fetched) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_HALTED;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      // RUN/STEP/NOP are accepted here but have no effect.
      S_HALTED: begin
        if (cmd_accept && (cmd == CMD_CLEAR)) begin
          state_d = S_FLUSH;
        end
      end

      S_FLUSH: begin
        state_d = S_IDLE;
        drain_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        drain_d = '0;
      end
    endcase
  end

  // Cleared on entry to FLUSH so the count already reads 0 during the flush.
  always_comb begin
    count_d = count_q;
    if ((state_d == S_FLUSH) || (state_q == S_FLUSH)) begin
      count_d = '0;
    end else if (pipe_enable && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign ctrl.cmd_ready    = cmd_ready;
  assign ctrl.pipe_enable  = pipe_enable;
  assign ctrl.fetch_enable = (state_q == S_RUN) || (state_q == S_STEP);
  assign ctrl.pipe_flush   = (state_q == S_FLUSH);
  assign ctrl.halted       = (state_q == S_HALTED);
  assign ctrl.done         = done_q;
  assign ctrl.cycle_count  = count_q;

endmodule

// File: tb/tb_mips_exec_controller.sv
// Directed bench for mips_exec_controller: reset, RUN/HALT drain, STEP,
// breakpoint, halt/break priority, HALTED/CLEAR, saturation, mid-run reset.
module tb_mips_exec_controller;

  localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_CLR = 2'b11;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mips_exec_controller_if #(.ADDR_W(32), .CNT_W(32)) bus ();
  mips_exec_controller_if #(.ADDR_W(32), .CNT_W(3))  bus_s ();

  mips_exec_controller #(.DRAIN_CYCLES(4), .CNT_W(32), .ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus)
  );

  mips_exec_controller #(.DRAIN_CYCLES(4), .CNT_W(3), .ADDR_W(32)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {cmd_ready, pipe_enable, fetch_enable, pipe_flush, halted, done}
  function automatic logic [5:0] outs();
    return {bus.cmd_ready, bus.pipe_enable, bus.fetch_enable,
            bus.pipe_flush, bus.halted, bus.done};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b1;
    bus.cmd          = C_RUN;
    bus.halt_fetched = 1'b0;
    bus.pc           = '0;
    bus.break_en     = 1'b0;
    bus.break_addr   = '0;
    bus_s.cmd_valid  = 1'b0;
    bus_s.cmd        = C_NOP;
    bus_s.halt_fetched = 1'b0;
    bus_s.pc         = '0;
    bus_s.break_en   = 1'b0;
    bus_s.break_addr = '0;
    repeat (3) tick();
    n_checks++;
    if (outs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_outs: got %b expected %b", outs(), 6'b100000);
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 6'b100000 || bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_release: outs %b count %0d expected 100000 count 0",
               outs(), bus.cycle_count);
    end
  endtask

  task automatic test_run_halt();
    int pe = 0, fe = 0, dn = 0, c = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_RUN;
    tick();
    bus.cmd_valid = 1'b0;
    while (!bus.halted && c < 40) begin
      pe += int'(bus.pipe_enable);
      fe += int'(bus.fetch_enable);
      dn += int'(bus.done);
      bus.halt_fetched = (fe == 10 && bus.fetch_enable);
      tick();
      c++;
    end
    bus.halt_fetched = 1'b0;
    n_checks++;
    if (!bus.halted) begin
      n_fail++;
      $display("FAIL run_halt_timeout: halted %b after %0d cycles, expected 1", bus.halted, c);
    end
    n_checks++;
    if (pe !== 14 || fe !== 10) begin
      n_fail++;
      $display("FAIL run_halt_enables: pipe %0d fetch %0d expected 14 10", pe, fe);
    end
    n_checks++;
    if (outs() !== 6'b100011 || bus.cycle_count !== 32'd14 || dn !== 0) begin
      n_fail++;
      $display("FAIL run_halt_state: outs %b count %0d early_done %0d expected 100011 14 0",
               outs(), bus.cycle_count, dn);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b100010) begin
      n_fail++;
      $display("FAIL run_halt_done_pulse: got %b expected %b", outs(), 6'b100010);
    end
  endtask

  task automatic test_halted_clear();
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_STEP;
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (outs() !== 6'b100010 || bus.cycle_count !== 32'd14) begin
      n_fail++;
      $display("FAIL halted_step_ignored: outs %b count %0d expected 100010 14",
               outs(), bus.cycle_count);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b100010) begin
      n_fail++;
      $display("FAIL halted_stays: got %b expected %b", outs(), 6'b100010);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_CLR;
    tick();
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (outs() !== 6'b000100 || bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_flush: outs %b count %0d expected 000100 0",
               outs(), bus.cycle_count);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b100000 || bus.cycle_count !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_idle: outs %b count %0d expected 100000 0",
               outs(), bus.cycle_count);
    end
  endtask

  task automatic test_step();
    for (int k = 0; k < 3; k++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd       = C_STEP;
      tick();
      bus.cmd_valid = 1'b0;
      n_checks++;
      if (outs() !== 6'b011000) begin
        n_fail++;
        $display("FAIL step%0d_enabled: got %b expected %b", k, outs(), 6'b011000);
      end
      tick();
      n_checks++;
      if (outs() !== 6'b100001) begin
        n_fail++;
        $display("FAIL step%0d_done: got %b expected %b", k, outs(), 6'b100001);
      end
    end
    tick();
    n_checks++;
    if (outs() !== 6'b100000 || bus.cycle_count !== 32'd3) begin
      n_fail++;
      $display("FAIL step_final: outs %b count %0d expected 100000 3",
               outs(), bus.cycle_count);
    end
  endtask

  task automatic test_break();
    int  pe = 0, c = 0;
    logic fe_prev = 1'b0;
    bus.break_en   = 1'b1;
    bus.break_addr = 32'h10;
    bus.pc         = 32'h0;
    bus.cmd_valid  = 1'b1;
    bus.cmd        = C_RUN;
    tick();
    bus.cmd_valid = 1'b0;
    while (c < 30) begin
      if (fe_prev) bus.pc = bus.pc + 32'd4;
      if (bus.done) break;
      pe += int'(bus.pipe_enable);
      fe_prev = bus.fetch_enable;
      tick();
      c++;
    end
    n_checks++;
    if (pe !== 5 || c >= 30) begin
      n_fail++;
      $display("FAIL break_enables: pipe cycles %0d (loop %0d) expected 5", pe, c);
    end
    n_checks++;
    if (outs() !== 6'b100001 || bus.cycle_count !== 32'd8) begin
      n_fail++;
      $display("FAIL break_idle: outs %b count %0d expected 100001 8",
               outs(), bus.cycle_count);
    end
    tick();
    n_checks++;
    if (outs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL break_done_pulse: got %b expected %b", outs(), 6'b100000);
    end
  endtask

  task automatic test_halt_and_break();
    bus.pc         = 32'h40;
    bus.break_addr = 32'h40;
    bus.break_en   = 1'b1;
    bus.cmd_valid  = 1'b1;
    bus.cmd        = C_RUN;
    tick();
    bus.cmd_valid    = 1'b0;
    bus.halt_fetched = 1'b1;
    n_checks++;
    if (outs() !== 6'b011000) begin
      n_fail++;
      $display("FAIL hb_run: got %b expected %b", outs(), 6'b011000);
    end
    tick();
    // CLEAR offered during drain must not be taken; halt stays high and is ignored.
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_CLR;
    for (int d = 0; d < 4; d++) begin
      n_checks++;
      if (outs() !== 6'b010000) begin
        n_fail++;
        $display("FAIL hb_drain%0d: got %b expected %b", d, outs(), 6'b010000);
      end
      tick();
      bus.cmd_valid = 1'b0;
    end
    bus.halt_fetched = 1'b0;
    n_checks++;
    if (outs() !== 6'b100011 || bus.cycle_count !== 32'd13) begin
      n_fail++;
      $display("FAIL hb_halted: outs %b count %0d expected 100011 13",
               outs(), bus.cycle_count);
    end
    bus.break_en = 1'b0;
  endtask

  task automatic test_saturate();
    bus_s.cmd_valid = 1'b1;
    bus_s.cmd       = C_RUN;
    tick();
    bus_s.cmd_valid = 1'b0;
    repeat (6) tick();
    n_checks++;
    if (bus_s.cycle_count !== 3'd6) begin
      n_fail++;
      $display("FAIL sat_before: got %0d expected 6", bus_s.cycle_count);
    end
    repeat (4) tick();
    n_checks++;
    if (bus_s.cycle_count !== 3'd7 || bus_s.pipe_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: count %0d pipe %b expected 7 1",
               bus_s.cycle_count, bus_s.pipe_enable);
    end
  endtask

  task automatic test_reset_mid_run();
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_CLR;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_RUN;
    tick();
    bus.cmd_valid = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (outs() !== 6'b011000 || bus.cycle_count !== 32'd3) begin
      n_fail++;
      $display("FAIL mid_run_pre: outs %b count %0d expected 011000 3",
               outs(), bus.cycle_count);
    end
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd       = C_RUN;
    tick();
    n_checks++;
    if (outs() !== 6'b100000 || bus.cycle_count !== 32'd0 ||
        bus_s.pipe_enable !== 1'b0 || bus_s.cycle_count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_run_reset: outs %b count %0d sat_pipe %b expected 100000 0 0",
               outs(), bus.cycle_count, bus_s.pipe_enable);
    end
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (outs() !== 6'b100000) begin
      n_fail++;
      $display("FAIL mid_run_release: got %b expected %b", outs(), 6'b100000);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_run_halt();
    test_halted_clear();
    test_step();
    test_break();
    test_halt_and_break();
    test_saturate();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
